control_seq: RTL
================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter MEM_WAIT, default 0, sets the extra wait cycles (0..7) added to any execute cycle that touches memory.
REQ-002 Parameter ENABLE_HALT, default 1, makes dest==7 a HALT when 1; when 0, dest==7 is a NOP.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 run  input  1  sequencer enable; 0 freezes the machine in FETCH.
REQ-006 mem_data  input  8  memory read data, captured as the instruction in FETCH.
REQ-007 alu_zero  input  1  ALU result-is-zero, sampled when A commits.
REQ-008 alu_carry  input  1  ALU carry-out, sampled when A commits.
REQ-009 load_ir, load_pc, load_a, load_b, load_x, do_out, store_mem  output  1 each  register and memory write strobes.
REQ-010 assert_m, assert_e, assert_a, assert_x  output  1 each  bus-source selects, one-hot or all-0.
REQ-011 immediate, do_subtract, do_jump, pc_inc  output  1 each  addressing mode, ALU op, taken jump, PC increment.
REQ-012 phase  output  2  current state: 0=FETCH, 1=EXEC, 2=WAIT, 3=HALT.
REQ-013 halted  output  1  high while in HALT.

Function
REQ-014 The instruction register ir_q (8 bits) SHALL be split as {bit7, bit6, source[1:0], dest[2:0], indexed}.
REQ-015 FETCH, run=1: assert assert_m=1, load_ir=1, pc_inc=1, all other strobes 0; capture ir_q<=mem_data; next state EXEC.
REQ-016 FETCH, run=0: all outputs 0; state and ir_q hold.
REQ-017 EXEC and WAIT source decode: assert_m=(source==0), assert_e=(source==1), assert_a=(source==2), assert_x=(source==3).
REQ-018 EXEC and WAIT dest decode: dest 1 = PC, 2 = A, 3 = X, 4 = B, 5 = store, 6 = out; dest 0 = NOP.
REQ-019 immediate=~indexed; do_subtract=bit6 in EXEC and WAIT.
REQ-020 jump_ctl=(bit6 & zero_q) | (bit7 & carry_q) | (bit6 & bit7); load_pc = do_jump = (dest==1) & jump_ctl.
REQ-021 An instruction is "memory" when source==0 or dest==5.
REQ-022 A non-memory instruction, or any instruction with MEM_WAIT=0, SHALL complete in one EXEC cycle, then go to FETCH.
REQ-023 A memory instruction with MEM_WAIT=N>0: EXEC is followed by exactly N WAIT cycles, then FETCH.
REQ-024 In that case, source selects, immediate and do_subtract are held for all N+1 cycles; write strobes and do_jump assert only in the final WAIT cycle.
REQ-025 A 3-bit wait counter SHALL load N on EXEC, decrement each WAIT cycle and leave WAIT at 1; it never wraps.
REQ-026 pc_inc=1 in the final execute cycle when immediate=1 and the instruction is memory, unless do_jump=1 in that cycle.
REQ-027 do_jump has priority over pc_inc in the same cycle.
REQ-028 zero_q<=alu_zero and carry_q<=alu_carry SHALL update only on a cycle where load_a=1; otherwise they hold.
REQ-029 Flags written by an instruction SHALL be visible to jump_ctl from the next instruction onward.
REQ-030 dest==7 with ENABLE_HALT=1: no strobes in EXEC, next state HALT.
REQ-031 HALT: all outputs 0 except halted=1; HALT is left only by reset, and run is ignored.
REQ-032 run is sampled only in FETCH; deasserting run in EXEC or WAIT lets the instruction finish.
REQ-033 Outputs SHALL be combinational from state, ir_q, flags and wait counter, with no dependence on alu_* in the same cycle.

Reset
REQ-034 reset_n=0 SHALL immediately force state FETCH, ir_q=0x00, zero_q=0, carry_q=0, wait counter 0, and all strobes and halted to 0.
REQ-035 Reset in EXEC or WAIT SHALL abort the instruction with no strobe emitted after reset_n falls.
REQ-036 After reset_n rises, the first FETCH SHALL occur on the first clk edge with run=1.

Verification
REQ-037 MEM_WAIT=0, run=1, mem_data=0x04 -> FETCH cycle (load_ir, pc_inc, assert_m), then one EXEC cycle with assert_m, load_a, immediate, pc_inc; phase 0,1,0.
REQ-038 MEM_WAIT=2, instruction 0x2B -> EXEC plus 2 WAIT cycles with assert_a held; store_mem=1 only in the 3rd cycle; pc_inc=0.
REQ-039 Flags: alu_zero=1 on a load_a, then 0x42 -> do_jump=1, load_pc=1, pc_inc=0; with alu_zero=0 instead -> do_jump=0, pc_inc=1.
REQ-040 0xC2 with zero_q=0 and carry_q=0 -> do_jump=1 (unconditional).
REQ-041 0x0E, ENABLE_HALT=1 -> HALT with halted=1, held 10 cycles with run toggling; ENABLE_HALT=0 -> NOP and return to FETCH.
REQ-042 reset_n pulsed low during WAIT, MEM_WAIT=3 -> outputs 0 within the same cycle; phase=0 and no store_mem seen afterward.

Source files
------------

// File: rtl/control_seq.sv
// control_seq: instruction sequencer with FETCH/EXEC/WAIT/HALT states and memory wait stretching
module control_seq #(
   parameter int MEM_WAIT = 0,
   parameter bit ENABLE_HALT = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   input  logic [7:0] mem_data,
   input  logic       alu_zero,
   input  logic       alu_carry,
   output logic       load_ir,
   output logic       load_pc,
   output logic       load_a,
   output logic       load_b,
   output logic       load_x,
   output logic       do_out,
   output logic       store_mem,
   output logic       assert_m,
   output logic       assert_e,
   output logic       assert_a,
   output logic       assert_x,
   output logic       immediate,
   output logic       do_subtract,
   output logic       do_jump,
   output logic       pc_inc,
   output logic [1:0] phase,
   output logic       halted
);
   typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MWAIT = 2'd2, HALT = 2'd3} state_t;
   state_t state;
   logic [7:0] irQ;
   logic zeroQ, carryQ;
   logic [2:0] waitCnt;
   logic [1:0] src;
   logic [2:0] dest;
   logic isHalt, isMem, stretch, fetch, active, lastCyc, commit, jumpCtl;
   assign src = irQ[5:4];
   assign dest = irQ[3:1];
   assign isHalt = ENABLE_HALT && dest == 3'd7;
   assign isMem = src == 2'd0 || dest == 3'd5;
   assign stretch = isMem && MEM_WAIT != 0;
   assign fetch = state == FETCH && run && reset_n;
   assign active = (state == EXEC || state == MWAIT) && !isHalt;
   assign lastCyc = state == EXEC ? !stretch : waitCnt <= 3'd1;
   assign commit = active && lastCyc;
   assign jumpCtl = (irQ[6] && zeroQ) || (irQ[7] && carryQ) || (irQ[6] && irQ[7]);
   assign do_jump = commit && dest == 3'd1 && jumpCtl;
   assign load_pc = do_jump;
   assign load_a = commit && dest == 3'd2;
   assign load_x = commit && dest == 3'd3;
   assign load_b = commit && dest == 3'd4;
   assign store_mem = commit && dest == 3'd5;
   assign do_out = commit && dest == 3'd6;
   assign load_ir = fetch;
   assign assert_m = fetch || (active && src == 2'd0);
   assign assert_e = active && src == 2'd1;
   assign assert_a = active && src == 2'd2;
   assign assert_x = active && src == 2'd3;
   assign immediate = active && !irQ[0];
   assign do_subtract = active && irQ[6];
   assign pc_inc = fetch || (commit && !irQ[0] && isMem && !do_jump);
   assign phase = state;
   assign halted = state == HALT;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= FETCH;
         irQ <= 8'h00;
         zeroQ <= 1'b0;
         carryQ <= 1'b0;
         waitCnt <= 3'd0;
      end else begin
         if (load_a) begin
            zeroQ <= alu_zero;
            carryQ <= alu_carry;
         end
         case (state)
            FETCH: if (run) begin
               irQ <= mem_data;
               state <= EXEC;
            end
            EXEC: begin
               waitCnt <= 3'(MEM_WAIT);
               state <= isHalt ? HALT : stretch ? MWAIT : FETCH;
            end
            MWAIT: if (waitCnt <= 3'd1) state <= FETCH; else waitCnt <= waitCnt - 3'd1;
            default: state <= HALT;
         endcase
      end
   end
endmodule
